// File: rtl/posit_fma_out_buffer.sv
// Two-entry skid buffer behind posit_fma: registers result/status/tag so that
// out_ready_i never reaches in_ready_o combinationally. Also tracks retired-op statistics.
module posit_fma_out_buffer #(
   parameter int unsigned pFormat = 0,
   parameter int unsigned CNT_W   = 32,
   // Format code -> posit width: 0:32, 1:16, 2:8, 3:64
   localparam int unsigned WIDTH  = (pFormat == 1) ? 16 :
                                    (pFormat == 2) ? 8  :
                                    (pFormat == 3) ? 64 : 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] result_i,
   input  logic [4:0]       status_i,
   input  logic             tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic [4:0]       status_o,
   output logic             tag_o,
   output logic             busy_o,
   input  logic             clr_sticky_i,
   output logic [4:0]       sticky_o,
   output logic [CNT_W-1:0] retired_o,
   output logic [1:0]       dbg_state_o
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both high.
   // valid never waits on ready; ready here depends only on the state register.
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e             state_q;
   logic [WIDTH-1:0]   h_result_q, s_result_q;
   logic [4:0]         h_status_q, s_status_q;
   logic               h_tag_q, s_tag_q;
   logic [4:0]         sticky_q, sticky_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic               push, pop;

   assign in_ready_o  = (state_q != FULL);
   assign out_valid_o = (state_q != EMPTY);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;
   assign busy_o      = (state_q != EMPTY) | in_valid_i;
   assign result_o    = h_result_q;
   assign status_o    = h_status_q;
   assign tag_o       = h_tag_q;
   assign sticky_o    = sticky_q;
   assign retired_o   = retired_q;
   assign dbg_state_o = state_q;

   // A clear coinciding with a pop keeps only the popped entry's contribution.
   always_comb begin
      sticky_d  = sticky_q;
      retired_d = retired_q;
      if (clr_sticky_i) begin
         sticky_d  = '0;
         retired_d = '0;
      end
      if (pop) begin
         sticky_d  = sticky_d | h_status_q;
         retired_d = retired_d + CNT_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= EMPTY;
         h_result_q <= '0;
         h_status_q <= '0;
         h_tag_q    <= 1'b0;
         s_result_q <= '0;
         s_status_q <= '0;
         s_tag_q    <= 1'b0;
         sticky_q   <= '0;
         retired_q  <= '0;
      end else if (flush_i) begin
         state_q <= EMPTY;
         if (clr_sticky_i) begin
            sticky_q  <= '0;
            retired_q <= '0;
         end
      end else begin
         sticky_q  <= sticky_d;
         retired_q <= retired_d;
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_q    <= ONE;
                  h_result_q <= result_i;
                  h_status_q <= status_i;
                  h_tag_q    <= tag_i;
               end
            end
            ONE: begin
               if (push && pop) begin
                  h_result_q <= result_i;
                  h_status_q <= status_i;
                  h_tag_q    <= tag_i;
               end else if (push) begin
                  state_q    <= FULL;
                  s_result_q <= result_i;
                  s_status_q <= status_i;
                  s_tag_q    <= tag_i;
               end else if (pop) begin
                  state_q <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  state_q    <= ONE;
                  h_result_q <= s_result_q;
                  h_status_q <= s_status_q;
                  h_tag_q    <= s_tag_q;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
      !(state_q == FULL && push));
   a_stable_bp: assert property (@(posedge clk_i) disable iff (rst_i)
      (out_valid_o && !out_ready_i && !flush_i) |=>
      ($stable(result_o) && $stable(status_o) && $stable(tag_o)));
   a_legal_state: assert property (@(posedge clk_i)
      state_q inside {EMPTY, ONE, FULL});

endmodule

// File: tb/tb_posit_fma_out_buffer.sv
// Bench for posit_fma_out_buffer: vector table for handshake/state behaviour,
// hand sequences for the corner cases, scoreboard queue for data order.
module tb_posit_fma_out_buffer;

   localparam int W  = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready, clr;
   logic [W-1:0]  res_in;
   logic [4:0]    st_in;
   logic          tag_in;
   logic          in_ready_o, out_valid_o, tag_o, busy_o;
   logic [W-1:0]  result_o;
   logic [4:0]    status_o, sticky_o;
   logic [CW-1:0] retired_o;
   logic [1:0]    dbg_state_o;

   posit_fma_out_buffer #(.pFormat(0), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready_o),
      .result_i(res_in), .status_i(st_in), .tag_i(tag_in),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready),
      .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
      .busy_o(busy_o), .clr_sticky_i(clr),
      .sticky_o(sticky_o), .retired_o(retired_o), .dbg_state_o(dbg_state_o)
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   logic [W+5:0]  exp_q[$];
   logic [W+5:0]  sb_e;
   logic [4:0]    m_sticky;
   logic [CW-1:0] m_retired;
   logic          sb_popped;

   typedef struct {
      logic         iv;
      logic         rdy;
      logic [W-1:0] res;
      logic [4:0]   st;
      logic         tag;
      logic         ov;
      logic         ir;
      logic [1:0]   state;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic rdy, input logic [W-1:0] r,
                        input logic [4:0] s, input logic t);
      in_valid  = iv;
      out_ready = rdy;
      res_in    = r;
      st_in     = s;
      tag_in    = t;
   endtask

   // Scoreboard and statistics model, sampled mid-cycle when inputs are settled.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_sticky  = '0;
         m_retired = '0;
      end else if (flush) begin
         exp_q.delete();
         if (clr) begin
            m_sticky  = '0;
            m_retired = '0;
         end
      end else begin
         sb_popped = 1'b0;
         if (out_valid_o && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_underflow: got %0h expected no output", result_o);
            end else begin
               sb_e = exp_q.pop_front();
               sb_popped = 1'b1;
               if ({tag_o, status_o, result_o} !== sb_e) begin
                  n_err++;
                  $display("FAIL sb_data: got %0h expected %0h", {tag_o, status_o, result_o}, sb_e);
               end
            end
         end
         if (clr) begin
            m_sticky  = '0;
            m_retired = '0;
         end
         if (sb_popped) begin
            m_sticky  = m_sticky | sb_e[W+4:W];
            m_retired = m_retired + 1'b1;
         end
         if (in_valid && in_ready_o)
            exp_q.push_back({tag_in, st_in, res_in});
      end
   end

   initial begin
      logic [W-1:0]  a, b;
      logic [CW-1:0] saved_ret;

      tbl[0] = '{1'b1, 1'b0, 32'h11111111, 5'b00001, 1'b0, 1'b1, 1'b1, 2'd1};
      tbl[1] = '{1'b1, 1'b0, 32'h22222222, 5'b00100, 1'b1, 1'b1, 1'b0, 2'd2};
      tbl[2] = '{1'b1, 1'b0, 32'h33333333, 5'b10000, 1'b0, 1'b1, 1'b0, 2'd2};
      tbl[3] = '{1'b0, 1'b1, 32'h0,        5'b00000, 1'b0, 1'b1, 1'b1, 2'd1};
      tbl[4] = '{1'b0, 1'b1, 32'h0,        5'b00000, 1'b0, 1'b0, 1'b1, 2'd0};
      tbl[5] = '{1'b1, 1'b1, 32'h44444444, 5'b01000, 1'b1, 1'b1, 1'b1, 2'd1};
      tbl[6] = '{1'b1, 1'b1, 32'h55555555, 5'b00010, 1'b0, 1'b1, 1'b1, 2'd1};
      tbl[7] = '{1'b0, 1'b0, 32'h0,        5'b00000, 1'b0, 1'b1, 1'b1, 2'd1};
      tbl[8] = '{1'b0, 1'b1, 32'h0,        5'b00000, 1'b0, 1'b0, 1'b1, 2'd0};

      rst = 1'b1; flush = 1'b0; clr = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      step(); step();
      chk("rst_ov", out_valid_o, 0);
      chk("rst_ir", in_ready_o, 1);
      chk("rst_res", result_o, 0);
      chk("rst_stat_tag", {status_o, tag_o}, 0);
      chk("rst_stats", {sticky_o, retired_o}, 0);
      chk("rst_busy", busy_o, 0);
      rst = 1'b0;

      // Single push, one-cycle latency
      drive(1'b1, 1'b1, 32'h40000000, 5'b0, 1'b1);
      step();
      chk("single_ov", out_valid_o, 1);
      chk("single_res", result_o, 32'h40000000);
      chk("single_tag", tag_o, 1);
      drive(1'b0, 1'b1, '0, '0, 1'b0);
      step();
      chk("single_ov_after", out_valid_o, 0);
      chk("single_retired", retired_o, 1);

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].iv, tbl[i].rdy, tbl[i].res, tbl[i].st, tbl[i].tag);
         step();
         chk($sformatf("tbl%0d_ov", i), out_valid_o, tbl[i].ov);
         chk($sformatf("tbl%0d_ir", i), in_ready_o, tbl[i].ir);
         chk($sformatf("tbl%0d_state", i), dbg_state_o, tbl[i].state);
      end
      chk("tbl_retired", retired_o, m_retired);
      chk("tbl_sticky", sticky_o, m_sticky);

      // Eight back-to-back pushes at full throughput
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         step();
         chk($sformatf("stream%0d_ir", i), in_ready_o, 1);
         chk($sformatf("stream%0d_ov", i), out_valid_o, 1);
      end
      drive(1'b0, 1'b1, '0, '0, 1'b0);
      step();
      chk("stream_drain", out_valid_o, 0);

      // Backpressure: A then B, hold, release
      a = 32'hAAAA0001; b = 32'hBBBB0002;
      drive(1'b1, 1'b0, a, 5'b00001, 1'b0);
      step();
      drive(1'b1, 1'b0, b, 5'b00010, 1'b1);
      step();
      chk("bp_state", dbg_state_o, 2);
      chk("bp_ir", in_ready_o, 0);
      chk("bp_res_a", result_o, a);
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      step();
      chk("bp_res_a_hold", result_o, a);
      out_ready = 1'b1;
      step();
      chk("bp_res_b", result_o, b);
      chk("bp_ov_b", out_valid_o, 1);
      step();
      chk("bp_empty", out_valid_o, 0);

      // FULL plus flush with a push attempt
      drive(1'b1, 1'b0, 32'hC0C0C0C0, 5'b0, 1'b0);
      step();
      drive(1'b1, 1'b0, 32'hD0D0D0D0, 5'b0, 1'b1);
      step();
      chk("fl_full", dbg_state_o, 2);
      saved_ret = m_retired;
      flush = 1'b1;
      drive(1'b1, 1'b1, 32'hEEEEEEEE, 5'b11111, 1'b1);
      step();
      flush = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      chk("fl_ov", out_valid_o, 0);
      chk("fl_ir", in_ready_o, 1);
      chk("fl_retired", retired_o, saved_ret);
      chk("fl_res_hold", result_o, 32'hC0C0C0C0);

      // Sticky accumulation and clear-with-pop
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_stats", {sticky_o, retired_o}, 0);
      drive(1'b1, 1'b1, 32'h1, 5'b00001, 1'b0);
      step();
      drive(1'b1, 1'b1, 32'h2, 5'b00100, 1'b0);
      step();
      drive(1'b1, 1'b1, 32'h3, 5'b00010, 1'b0);
      step();
      chk("sticky_nx_of", sticky_o, 5'b00101);
      chk("sticky_cnt2", retired_o, 2);
      drive(1'b0, 1'b1, '0, '0, 1'b0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clrpop_sticky", sticky_o, 5'b00010);
      chk("clrpop_retired", retired_o, 1);

      // Counter wrap: 17 retirements from zero on a 4-bit counter
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 1'b1, W'(i), 5'b0, 1'b0);
         step();
      end
      drive(1'b0, 1'b1, '0, '0, 1'b0);
      step();
      chk("wrap_retired", retired_o, 1);
      chk("wrap_model", retired_o, m_retired);

      // Reset while FULL
      drive(1'b1, 1'b0, 32'h12345678, 5'b11111, 1'b1);
      step();
      drive(1'b1, 1'b0, 32'h9ABCDEF0, 5'b10101, 1'b1);
      step();
      chk("mr_full", dbg_state_o, 2);
      rst = 1'b1;
      step();
      chk("mr_ov", out_valid_o, 0);
      chk("mr_ir", in_ready_o, 1);
      chk("mr_state", dbg_state_o, 0);
      chk("mr_data", {result_o, status_o, tag_o}, 0);
      chk("mr_stats", {sticky_o, retired_o}, 0);
      rst = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      step();
      chk("mr_hold_empty", out_valid_o, 0);
      chk("sb_left", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
